psum_collector: RTL and testbench
=================================

Name: psum_collector

Overview:
- South-edge receiver for a row of MAC columns. Consumes the per-column psum bus and per-column valid bits, which are skewed by one cycle per column (column i fires i cycles after column 0).
- Deskews the columns into aligned row vectors and buffers them in a small FIFO.
- Presents the vectors to the downstream SRAM/ofifo writer over a valid/ready handshake.

Parameters:
- psum_bw, 16, width of one column psum (two's complement)
- col, 8, number of columns in the row
- depth, 4, output FIFO depth in row vectors (power of 2, >=2)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- in_s  input  psum_bw*col  psum bus from the row; column i occupies [i*psum_bw +: psum_bw]
- valid_in  input  col  per-column valid; column i pulses i cycles after column 0 of the same wave
- out_data  output  psum_bw*col  aligned row vector at FIFO head; same column packing as in_s
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  downstream accepts the head when out_valid && out_ready
- vec_cnt  output  16  row vectors pushed since reset; wraps 0xFFFF->0
- overflow  output  1  sticky; an aligned vector arrived while the FIFO was full
- skew_err  output  1  sticky; aligned valid bits disagreed (partial wave)

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears deskew pipes, FIFO pointers, vec_cnt, overflow and skew_err.
  - out_valid=0; out_data=0.
  - A reset mid-wave discards every partially aligned wave.
- Deskew:
  - Column i data and valid pass through a (col-1-i)-stage register pipe. Column col-1 has zero stages.
  - Pipe data stages load only when their own valid is 1; valid stages always shift.
  - A wave that starts at column 0 in cycle t is aligned in cycle t+col-1 (combinational at the pipe outputs).
- Push rule (evaluated on aligned valid bits av[col-1:0]):
  - av all ones: push the aligned vector.
  - av all zeros: no action.
  - any other pattern: set skew_err; no push; the partial data is dropped.
- Waves may arrive back-to-back, one per cycle; each wave occupies its own pipe slot, so there is no interference between waves.
- Total latency: column 0 valid in cycle t -> out_valid high in cycle t+col (one FIFO write cycle), provided the FIFO was empty.
- FIFO:
  - depth entries; out_data is the registered head entry.
  - Pop when out_valid && out_ready.
  - Full: a push is dropped, overflow is set, vec_cnt is not incremented.
  - Simultaneous push and pop when full: the pop frees the slot, the push succeeds, no overflow.
  - Simultaneous push and pop when empty: the push is written; out_valid rises the next cycle (no fall-through).
  - Pointers wrap modulo depth; an extra pointer bit distinguishes full from empty.
- vec_cnt increments by 1 on every successful push.
- out_data holds its value while out_valid && !out_ready.

Optional Feature:
- Macro PSUM_COLLECTOR_RELU_EN.
- Defined: each column of an aligned vector is replaced by 0 if its sign bit is 1, before the FIFO write. The comparison is signed over psum_bw bits, and the stored/output values are post-ReLU.
- Undefined: vectors are stored unmodified; no ReLU logic is synthesised.

Test Plan:
1. Reset, then one wave with column i psum = 0x0100+i (valid_in skewed i cycles) -> out_valid rises 8 cycles after column 0 valid; out_data columns 0..7 = 0x0100..0x0107; vec_cnt=1.
2. 6 consecutive waves, one per cycle, out_ready=0, depth=4 -> 4 vectors stored, overflow=1, vec_cnt=4. Then out_ready=1 -> the first 4 waves are drained in order; out_valid falls after 4 pops.
3. Wave where column 5 valid is missing -> skew_err=1, no push, vec_cnt unchanged. The next full wave still pushes correctly.
4. FIFO full with out_ready=1 in the same cycle a new aligned wave arrives -> push accepted, overflow stays 0, occupancy remains 4.
5. Assert reset (0) while 3 columns of a wave are in flight, then release -> all outputs zero; no vector ever appears from the aborted wave.
6. With PSUM_COLLECTOR_RELU_EN defined, a wave containing 0xFFF0 and 0x0010 -> output columns 0x0000 and 0x0010. Without the macro -> 0xFFF0 and 0x0010 unchanged.

Source files
------------

// File: rtl/psum_collector_if.sv
// ---------------------------------------------------------------------------
// psum_collector_if
//   Bundles the row-side psum bus and the downstream valid/ready handshake
//   of psum_collector.
//
//   Signals:
//     in_s      psum bus from the MAC row, column i at [i*psum_bw +: psum_bw]
//     valid_in  per-column valid, column i skewed i cycles after column 0
//     out_data  aligned row vector at the FIFO head (same packing as in_s)
//     out_valid FIFO non-empty
//     out_ready downstream accepts the head when out_valid && out_ready
//
//   Modports:
//     master  drives the row bus and out_ready (MAC row + writer side)
//     slave   the collector itself
// ---------------------------------------------------------------------------
interface psum_collector_if #(
    parameter int psum_bw = 16,
    parameter int col     = 8
);
    logic [psum_bw*col-1:0] in_s;
    logic [col-1:0]         valid_in;
    logic [psum_bw*col-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output in_s, valid_in, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  in_s, valid_in, out_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/psum_collector.sv
// ---------------------------------------------------------------------------
// psum_collector
//   South-edge receiver for a row of MAC columns. Column i of the psum bus
//   fires i cycles after column 0; a (col-1-i)-stage pipe per column lines
//   the columns back up, complete waves are written into a small FIFO and
//   the FIFO head is offered downstream over valid/ready.
//
//   Ports:
//     clk       clock, all state on the rising edge
//     reset     asynchronous active-low reset
//     bus       psum_collector_if.slave (in_s, valid_in, out_data,
//               out_valid, out_ready)
//     vec_cnt   row vectors pushed since reset, wraps 0xFFFF -> 0
//     overflow  sticky, a complete wave arrived while the FIFO was full
//     skew_err  sticky, aligned valid bits disagreed (partial wave dropped)
//
//   Build option:
//     PSUM_COLLECTOR_RELU_EN  when defined, negative columns are clamped to
//                             zero before the FIFO write.
// ---------------------------------------------------------------------------
module psum_collector #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int depth   = 4
) (
    input  logic               clk,
    input  logic               reset,
    psum_collector_if.slave    bus,
    output logic [15:0]        vec_cnt,
    output logic               overflow,
    output logic               skew_err
);

    localparam int AW = $clog2(depth);

    typedef logic [psum_bw*col-1:0] vec_t;

    logic [col-1:0] av;   // aligned valid bits
    vec_t           ad;   // aligned data
    vec_t           wd;   // data written into the FIFO

    // ------------------------------------------------------------------
    // Deskew: column i is delayed by col-1-i cycles so every column of a
    // wave reaches the pipe outputs in the same cycle as column col-1.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < col; i++) begin : g_col
        localparam int STG = col - 1 - i;

        if (STG == 0) begin : g_direct
            assign av[i]                     = bus.valid_in[i];
            assign ad[i*psum_bw +: psum_bw]  = bus.in_s[i*psum_bw +: psum_bw];
        end else begin : g_pipe
            logic [psum_bw-1:0] d_q [STG];
            logic               v_q [STG];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < STG; k++) begin
                        d_q[k] <= '0;
                        v_q[k] <= 1'b0;
                    end
                end else begin
                    // NOTE: non-blocking assignments make every stage
                    // sample the previous stage's old value, so the
                    // order of these statements does not matter.
                    v_q[0] <= bus.valid_in[i];
                    if (bus.valid_in[i]) d_q[0] <= bus.in_s[i*psum_bw +: psum_bw];
                    for (int k = 1; k < STG; k++) begin
                        v_q[k] <= v_q[k-1];
                        // Data only moves with its valid; idle slots keep
                        // their contents and are ignored downstream.
                        if (v_q[k-1]) d_q[k] <= d_q[k-1];
                    end
                end
            end

            assign av[i]                    = v_q[STG-1];
            assign ad[i*psum_bw +: psum_bw] = d_q[STG-1];
        end
    end

    // ------------------------------------------------------------------
    // Optional ReLU on the aligned vector.
    // ------------------------------------------------------------------
    always_comb begin
        wd = ad;
`ifdef PSUM_COLLECTOR_RELU_EN
        for (int c = 0; c < col; c++) begin
            if ($signed(ad[c*psum_bw +: psum_bw]) < 0) wd[c*psum_bw +: psum_bw] = '0;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Output FIFO. Pointers carry one extra bit to tell full from empty.
    // ------------------------------------------------------------------
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [15:0] vec_cnt_q, vec_cnt_d;
    logic        overflow_q, overflow_d;
    logic        skew_err_q, skew_err_d;
    vec_t        mem_q [depth];

    logic empty, full, pop, push_req, push_ok;

    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop      = !empty && bus.out_ready;
    assign push_req = &av;
    // A pop in the same cycle frees the slot the push is about to use.
    assign push_ok  = push_req && (!full || pop);

    // NOTE: every variable gets a default at the top of the block, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        wptr_d     = wptr_q + {{AW{1'b0}}, push_ok};
        rptr_d     = rptr_q + {{AW{1'b0}}, pop};
        vec_cnt_d  = vec_cnt_q + {15'd0, push_ok};
        overflow_d = overflow_q | (push_req && !push_ok);
        skew_err_d = skew_err_q | ((|av) && !(&av));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            vec_cnt_q  <= '0;
            overflow_q <= 1'b0;
            skew_err_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            vec_cnt_q  <= vec_cnt_d;
            overflow_q <= overflow_d;
            skew_err_q <= skew_err_d;
        end
    end

    // NOTE: the storage array has no reset; it is only read through
    // pointers that reset clears, and out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= wd;
    end

    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign vec_cnt       = vec_cnt_q;
    assign overflow      = overflow_q;
    assign skew_err      = skew_err_q;

endmodule

// File: tb/tb_psum_collector.sv
// ---------------------------------------------------------------------------
// tb_psum_collector
//   Directed bench for psum_collector. Waves are scheduled column by column
//   with the row skew; expected row vectors go into a queue when a wave is
//   launched and are popped when the DUT hands a vector downstream.
// ---------------------------------------------------------------------------
module tb_psum_collector;

    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int DEPTH   = 4;

    typedef logic [PSUM_BW*COL-1:0] vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] vec_cnt;
    logic        overflow;
    logic        skew_err;

    psum_collector_if #(.psum_bw(PSUM_BW), .col(COL)) bus ();

    psum_collector #(.psum_bw(PSUM_BW), .col(COL), .depth(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .vec_cnt  (vec_cnt),
        .overflow (overflow),
        .skew_err (skew_err)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    vec_t exp_q [$];

    vec_t           wave_data  [$];
    logic [COL-1:0] wave_mask  [$];
    int             wave_start [$];

    task automatic check(input string tag, input vec_t obs, input vec_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic vec_t relu_model(input vec_t v);
        vec_t r;
        r = v;
`ifdef PSUM_COLLECTOR_RELU_EN
        for (int c = 0; c < COL; c++) begin
            if (v[c*PSUM_BW + PSUM_BW - 1]) r[c*PSUM_BW +: PSUM_BW] = '0;
        end
`endif
        return r;
    endfunction

    function automatic vec_t make_wave(input logic [15:0] base);
        vec_t v;
        for (int c = 0; c < COL; c++) v[c*PSUM_BW +: PSUM_BW] = base + 16'(c);
        return v;
    endfunction

    // Schedule a wave whose column 0 fires in the next driven cycle.
    task automatic add_wave(input vec_t data, input logic [COL-1:0] mask, input bit store);
        wave_data.push_back(data);
        wave_mask.push_back(mask);
        wave_start.push_back(cyc + 1);
        if (store) exp_q.push_back(relu_model(data));
    endtask

    // Idle columns carry random data so the pipes must ignore it.
    task automatic drive();
        vec_t           d;
        logic [COL-1:0] v;
        for (int i = 0; i < COL; i++) begin
            d[i*PSUM_BW +: PSUM_BW] = PSUM_BW'($urandom);
            v[i] = 1'b0;
        end
        for (int w = 0; w < wave_start.size(); w++) begin
            int             c;
            vec_t           wd;
            logic [COL-1:0] wm;
            c  = cyc - wave_start[w];
            wd = wave_data[w];
            wm = wave_mask[w];
            if (c >= 0 && c < COL) begin
                if (wm[c]) begin
                    v[c] = 1'b1;
                    d[c*PSUM_BW +: PSUM_BW] = wd[c*PSUM_BW +: PSUM_BW];
                end
            end
        end
        bus.in_s     = d;
        bus.valid_in = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    // Scoreboard: every accepted head must be the oldest expected vector.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL pop_unexpected: observed %h expected no vector", bus.out_data);
            end else begin
                check("pop_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        bus.in_s      = '0;
        bus.valid_in  = '0;
        bus.out_ready = 1'b0;
        reset         = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", vec_t'(bus.out_valid), '0);
        check("rst_out_data",  bus.out_data,          '0);
        check("rst_vec_cnt",   vec_t'(vec_cnt),       '0);
        check("rst_overflow",  vec_t'(overflow),      '0);
        check("rst_skew_err",  vec_t'(skew_err),      '0);
        reset = 1'b1;

        // 1: single wave, latency and contents
        add_wave(make_wave(16'h0100), '1, 1'b1);
        tick();
        for (int k = 1; k < COL; k++) begin
            tick();
            check("t1_no_early_valid", vec_t'(bus.out_valid), '0);
        end
        tick();
        check("t1_out_valid", vec_t'(bus.out_valid), vec_t'(1));
        check("t1_out_data",  bus.out_data,          make_wave(16'h0100));
        check("t1_vec_cnt",   vec_t'(vec_cnt),       vec_t'(1));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t1_drained", vec_t'(bus.out_valid), '0);

        // 2: six back-to-back waves into a 4-deep FIFO with no drain
        for (int w = 0; w < 6; w++) begin
            add_wave(make_wave(16'h0200 + 16'(16*w)), '1, w < DEPTH);
            tick();
        end
        repeat (COL + 1) tick();
        check("t2_overflow",  vec_t'(overflow),      vec_t'(1));
        check("t2_vec_cnt",   vec_t'(vec_cnt),       vec_t'(5));
        check("t2_out_valid", vec_t'(bus.out_valid), vec_t'(1));
        bus.out_ready = 1'b1;
        repeat (DEPTH) tick();
        check("t2_empty_after_4", vec_t'(bus.out_valid), '0);
        bus.out_ready = 1'b0;
        check("t2_queue_empty", vec_t'(exp_q.size()), '0);

        // 3: partial wave (column 5 missing), then a good wave
        add_wave(make_wave(16'h0300), 8'hDF, 1'b0);
        tick();
        repeat (COL + 1) tick();
        check("t3_skew_err",  vec_t'(skew_err),      vec_t'(1));
        check("t3_vec_cnt",   vec_t'(vec_cnt),       vec_t'(5));
        check("t3_no_push",   vec_t'(bus.out_valid), '0);
        bus.out_ready = 1'b1;
        add_wave(make_wave(16'h0400), '1, 1'b1);
        tick();
        repeat (COL + 1) tick();
        check("t3_vec_cnt_after", vec_t'(vec_cnt),       vec_t'(6));
        check("t3_drained",       vec_t'(bus.out_valid), '0);
        check("t3_queue_empty",   vec_t'(exp_q.size()),  '0);

        // 4: push and pop in the same cycle while full
        bus.out_ready = 1'b0;
        reset = 1'b0;
        #2;
        check("t4_rst_overflow", vec_t'(overflow), '0);
        check("t4_rst_skew_err", vec_t'(skew_err), '0);
        tick();
        reset = 1'b1;
        for (int w = 0; w < 5; w++) begin
            add_wave(make_wave(16'h0500 + 16'(16*w)), '1, 1'b1);
            tick();
        end
        repeat (COL - 1) tick();
        // FIFO holds 4; the fifth wave is aligned in this cycle.
        check("t4_full_cnt",   vec_t'(vec_cnt),       vec_t'(4));
        check("t4_full_valid", vec_t'(bus.out_valid), vec_t'(1));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t4_no_overflow", vec_t'(overflow), '0);
        check("t4_vec_cnt",     vec_t'(vec_cnt),  vec_t'(5));
        bus.out_ready = 1'b1;
        repeat (DEPTH) tick();
        check("t4_occupancy_4", vec_t'(bus.out_valid), '0);
        check("t4_queue_empty", vec_t'(exp_q.size()),  '0);
        bus.out_ready = 1'b0;

        // 5: reset with three columns of a wave in flight
        add_wave(make_wave(16'h0600), '1, 1'b0);
        tick();
        tick();
        tick();
        #3;
        reset = 1'b0;
        wave_data.delete();
        wave_mask.delete();
        wave_start.delete();
        #1;
        check("t5_rst_out_valid", vec_t'(bus.out_valid), '0);
        check("t5_rst_out_data",  bus.out_data,          '0);
        check("t5_rst_vec_cnt",   vec_t'(vec_cnt),       '0);
        check("t5_rst_overflow",  vec_t'(overflow),      '0);
        check("t5_rst_skew_err",  vec_t'(skew_err),      '0);
        tick();
        tick();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < COL + 4; k++) begin
            tick();
            check("t5_no_ghost", vec_t'(bus.out_valid), '0);
        end
        check("t5_vec_cnt",  vec_t'(vec_cnt),  '0);
        check("t5_skew_err", vec_t'(skew_err), '0);

        // 6: sign handling (ReLU when enabled, pass-through otherwise)
        begin
            vec_t        d;
            logic [15:0] exp_c0;
            d = make_wave(16'h0001);
            d[0*PSUM_BW +: PSUM_BW] = 16'hFFF0;
            d[1*PSUM_BW +: PSUM_BW] = 16'h0010;
            d[2*PSUM_BW +: PSUM_BW] = 16'h8000;
            d[3*PSUM_BW +: PSUM_BW] = 16'h7FFF;
`ifdef PSUM_COLLECTOR_RELU_EN
            exp_c0 = 16'h0000;
`else
            exp_c0 = 16'hFFF0;
`endif
            bus.out_ready = 1'b0;
            add_wave(d, '1, 1'b1);
            tick();
            repeat (COL) tick();
            check("t6_out_valid", vec_t'(bus.out_valid), vec_t'(1));
            check("t6_col0", vec_t'(bus.out_data[0*PSUM_BW +: PSUM_BW]), vec_t'(exp_c0));
            check("t6_col1", vec_t'(bus.out_data[1*PSUM_BW +: PSUM_BW]), vec_t'(16'h0010));
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            check("t6_vec_cnt",     vec_t'(vec_cnt),      vec_t'(1));
            check("t6_queue_empty", vec_t'(exp_q.size()), '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
